bip_fetch_unit: RTL and testbench

//  Read side of the BIP I program-address path. The PC drives an 11-bit Addr every Clk.

---
 rtl/bip_pkg.sv | 36 +++
 rtl/bip_fetch_unit_if.sv | 28 ++
 rtl/bip_prog_mem.sv | 35 +++
 rtl/bip_fetch_unit.sv | 105 ++++++++++
 tb/tb_bip_fetch_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared widths, opcodes and fetch FSM encoding for the BIP I fetch path
package bip_pkg;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 16;
    localparam int OPC_W     = 5;
    localparam int OPR_W     = DATA_W - OPC_W;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [OPC_W-1:0] {
        OPC_HLT  = 5'd0,
        OPC_STO  = 5'd1,
        OPC_LD   = 5'd2,
        OPC_LDI  = 5'd3,
        OPC_ADD  = 5'd4,
        OPC_ADDI = 5'd5,
        OPC_SUB  = 5'd6,
        OPC_SUBI = 5'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    function automatic logic [OPC_W-1:0] instr_opcode(input logic [DATA_W-1:0] instr);
        return instr[DATA_W-1 -: OPC_W];
    endfunction

    function automatic logic [OPR_W-1:0] instr_operand(input logic [DATA_W-1:0] instr);
        return instr[OPR_W-1:0];
    endfunction

endpackage

// File: rtl/bip_fetch_unit_if.sv
// rtl/bip_fetch_unit_if.sv - PC/loader side signals of the fetch unit
interface bip_fetch_unit_if;
    import bip_pkg::*;

    logic [ADDR_W-1:0] Addr;
    logic              Run;
    logic              LoadEn;
    logic              LoadValid;
    logic [DATA_W-1:0] LoadData;
    logic              LoadReady;
    logic              LoadDone;
    logic [DATA_W-1:0] Instr;
    logic [OPC_W-1:0]  Opcode;
    logic [OPR_W-1:0]  Operand;
    logic              InstrValid;
    logic              Halt;

    modport master (
        output Addr, Run, LoadEn, LoadValid, LoadData,
        input  LoadReady, LoadDone, Instr, Opcode, Operand, InstrValid, Halt
    );

    modport slave (
        input  Addr, Run, LoadEn, LoadValid, LoadData,
        output LoadReady, LoadDone, Instr, Opcode, Operand, InstrValid, Halt
    );

endinterface

// File: rtl/bip_prog_mem.sv
// rtl/bip_prog_mem.sv - single-port program RAM with registered, read-enabled output
module bip_prog_mem
    import bip_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] dout_q;

    // Array has no reset so a program survives Reset.
    always_ff @(posedge Clk) begin
        if (we_i) begin
            mem_q[addr_i] <= din_i;
        end
    end

    // Output register holds whenever no read is requested.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dout_q <= '0;
        end else if (re_i) begin
            dout_q <= mem_q[addr_i];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/bip_fetch_unit.sv
// rtl/bip_fetch_unit.sv - fetch FSM, program loader and instruction field split
module bip_fetch_unit
    import bip_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    bip_fetch_unit_if.slave  bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] instr;
    logic              xfer;
    logic              last_word;
    logic              halt_hit;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic              load_ready;
    logic              load_done;
    logic              halt;

    assign xfer      = (state_q == ST_LOAD) && bus.LoadValid;
    assign last_word = (ptr_q == {ADDR_W{1'b1}});
    assign halt_hit  = valid_q && (instr_opcode(instr) == OPC_HLT);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.LoadEn) begin
                    state_d = ST_LOAD;
                end else if (bus.Run) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (xfer && last_word) begin
                    state_d = ST_IDLE;
                end else if (!xfer && !bus.LoadEn) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Halt check uses the already-registered word, so it wins over Run=0.
                if (halt_hit) begin
                    state_d = ST_HALTED;
                end else if (!bus.Run) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == ST_LOAD);
        load_done  = xfer && last_word;
        halt       = (state_q == ST_HALTED);
        mem_we     = xfer;
        mem_re     = (state_q == ST_RUN) && (state_d == ST_RUN);
        mem_addr   = (state_q == ST_LOAD) ? ptr_q : bus.Addr;
        valid_d    = mem_re;
        ptr_d      = ptr_q;
        if ((state_q == ST_IDLE) && bus.LoadEn) begin
            ptr_d = '0;
        end else if (xfer) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    bip_prog_mem u_mem (
        .Clk    (Clk),
        .Reset  (Reset),
        .we_i   (mem_we),
        .re_i   (mem_re),
        .addr_i (mem_addr),
        .din_i  (bus.LoadData),
        .dout_o (instr)
    );

    assign bus.LoadReady  = load_ready;
    assign bus.LoadDone   = load_done;
    assign bus.Halt       = halt;
    assign bus.Instr      = instr;
    assign bus.Opcode     = instr_opcode(instr);
    assign bus.Operand    = instr_operand(instr);
    assign bus.InstrValid = valid_q;

endmodule

// File: tb/tb_bip_fetch_unit.sv
// tb/tb_bip_fetch_unit.sv - scoreboard bench for bip_fetch_unit
module tb_bip_fetch_unit;
    import bip_pkg::*;

    logic Clk;
    logic Reset;
    bip_fetch_unit_if bus ();

    bip_fetch_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #100 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] model [MEM_DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word(input int i);
        logic [OPC_W-1:0] op;
        logic [OPR_W-1:0] opr;
        op  = OPC_W'((i % 31) + 1);
        opr = OPR_W'(i) ^ 11'h2AA;
        return {op, opr};
    endfunction

    task automatic to_neg();
        @(negedge Clk);
    endtask

    task automatic to_drive();
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (!Reset && bus.LoadDone) done_cnt++;
        if (!Reset && bus.InstrValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(bus.Instr), 32'hDEAD);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                check("sb_instr", 32'(bus.Instr), 32'(e));
                check("sb_opcode", 32'(bus.Opcode), 32'(e[15:11]));
                check("sb_operand", 32'(bus.Operand), 32'(e[10:0]));
            end
        end
    end

    initial begin
        #(200 * 30000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] prog [3];
        logic [DATA_W-1:0] d6 [4];
        int base;
        prog[0] = 16'h1805; prog[1] = 16'h2003; prog[2] = 16'h0000;
        d6[0] = 16'h1111; d6[1] = 16'h2222; d6[2] = 16'h3333; d6[3] = 16'h4444;

        Reset = 1'b1;
        bus.Addr = '0; bus.Run = 1'b0; bus.LoadEn = 1'b0;
        bus.LoadValid = 1'b0; bus.LoadData = '0;
        #50;
        check("rst_instr", 32'(bus.Instr), 0);
        check("rst_valid", 32'(bus.InstrValid), 0);
        check("rst_halt", 32'(bus.Halt), 0);
        check("rst_ready", 32'(bus.LoadReady), 0);
        check("rst_done", 32'(bus.LoadDone), 0);
        check("rst_opcode", 32'(bus.Opcode), 0);
        check("rst_operand", 32'(bus.Operand), 0);
        #100;
        Reset = 1'b0;
        to_drive();
        to_neg();
        check("idle_ready", 32'(bus.LoadReady), 0);
        check("idle_valid", 32'(bus.InstrValid), 0);

        // small program load
        to_drive();
        bus.LoadEn = 1'b1;
        to_neg(); to_drive();
        for (int k = 0; k < 3; k++) begin
            bus.LoadValid = 1'b1; bus.LoadData = prog[k]; model[k] = prog[k];
            to_neg();
            check("load3_ready", 32'(bus.LoadReady), 1);
            check("load3_done", 32'(bus.LoadDone), 0);
            to_drive();
        end
        bus.LoadValid = 1'b0; bus.LoadEn = 1'b0;
        to_neg(); to_drive();
        to_neg();
        check("load3_exit_ready", 32'(bus.LoadReady), 0);

        // run until HLT
        to_drive();
        bus.Run = 1'b1; bus.Addr = 11'd0;
        to_neg(); to_drive();
        bus.Addr = 11'd0; exp_q.push_back(model[0]);
        to_neg();
        check("first_run_valid", 32'(bus.InstrValid), 0);
        to_drive();
        bus.Addr = 11'd1; exp_q.push_back(model[1]);
        to_neg();
        check("run_valid_rise", 32'(bus.InstrValid), 1);
        check("run_opcode", 32'(bus.Opcode), 3);
        check("run_operand", 32'(bus.Operand), 5);
        to_drive();
        bus.Addr = 11'd2; exp_q.push_back(model[2]);
        to_neg(); to_drive();
        bus.Addr = 11'd3;
        to_neg(); to_drive();
        for (int k = 4; k < 6; k++) begin
            bus.Addr = 11'(k);
            to_neg();
            check("halted_halt", 32'(bus.Halt), 1);
            check("halted_valid", 32'(bus.InstrValid), 0);
            check("halted_instr", 32'(bus.Instr), 0);
            to_drive();
        end

        // reset out of HALTED, then full-depth load
        Reset = 1'b1;
        #1;
        check("rst_halt_clear", 32'(bus.Halt), 0);
        check("rst_halt_valid", 32'(bus.InstrValid), 0);
        #49;
        Reset = 1'b0; bus.Run = 1'b0; bus.LoadEn = 1'b1;
        base = done_cnt;
        to_neg(); to_drive();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            bus.LoadValid = 1'b1; bus.LoadData = word(i); model[i] = word(i);
            to_neg();
            check("full_ready", 32'(bus.LoadReady), 1);
            check("full_done", 32'(bus.LoadDone), (i == MEM_DEPTH - 1) ? 1 : 0);
            to_drive();
            if (i != MEM_DEPTH - 1) begin
                bus.LoadValid = 1'b0;
                to_neg();
                check("full_gap_ready", 32'(bus.LoadReady), 1);
                check("full_gap_done", 32'(bus.LoadDone), 0);
                to_drive();
            end
        end
        bus.LoadValid = 1'b0; bus.LoadEn = 1'b0;
        to_neg();
        check("full_idle_ready", 32'(bus.LoadReady), 0);
        check("full_done_count", 32'(done_cnt - base), 1);

        // readback across the address wrap, then stop
        to_drive();
        bus.Run = 1'b1; bus.Addr = 11'd2046;
        to_neg(); to_drive();
        for (int k = 0; k < 4; k++) begin
            logic [ADDR_W-1:0] a;
            a = 11'(2046 + k);
            bus.Addr = a; exp_q.push_back(model[a]);
            to_neg(); to_drive();
        end
        bus.Run = 1'b0;
        to_neg(); to_drive();
        to_neg();
        check("stop_valid", 32'(bus.InstrValid), 0);
        check("stop_instr_hold", 32'(bus.Instr), 32'(word(1)));

        // aborted load, priority entry, partial reload
        to_drive();
        bus.LoadEn = 1'b1;
        to_neg(); to_drive();
        for (int k = 0; k < 4; k++) begin
            bus.LoadValid = 1'b1; bus.LoadData = d6[k]; model[k] = d6[k];
            to_neg(); to_drive();
        end
        bus.LoadValid = 1'b0; bus.LoadEn = 1'b1; bus.Run = 1'b1;
        #20 Reset = 1'b1;
        #1;
        check("abort_ready", 32'(bus.LoadReady), 0);
        #29 Reset = 1'b0;
        to_neg(); to_drive();
        bus.LoadValid = 1'b1; bus.LoadData = 16'h5555; model[0] = 16'h5555;
        to_neg();
        check("prio_load_ready", 32'(bus.LoadReady), 1);
        check("prio_load_valid", 32'(bus.InstrValid), 0);
        to_drive();
        bus.LoadData = 16'h6666; model[1] = 16'h6666;
        to_neg(); to_drive();
        bus.LoadValid = 1'b0; bus.LoadEn = 1'b0; bus.Run = 1'b0;
        to_neg(); to_drive();
        bus.Run = 1'b1; bus.Addr = 11'd0;
        to_neg(); to_drive();
        for (int k = 0; k < 4; k++) begin
            bus.Addr = 11'(k); exp_q.push_back(model[k]);
            to_neg(); to_drive();
        end
        bus.Addr = 11'd4;
        to_neg(); to_drive();
        #20 Reset = 1'b1;
        #1;
        check("rst_run_valid", 32'(bus.InstrValid), 0);
        check("rst_run_instr", 32'(bus.Instr), 0);
        #20 Reset = 1'b0; bus.Run = 1'b0;
        to_neg(); to_drive();
        to_neg();
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
